counter_sweep_ctrl: RTL
=======================

# counter_sweep_ctrl

Two-requester sweep controller for the shared 4-bit synchronous up/down counter. It arbitrates sweep commands round-robin and sequences the counter's reset, enable and direction inputs for the granted command. At the end of each sweep it checks the counter's final value against the expected value and reports done and error for the requester that was served.

## Interface
Parameters:
- CNT_W, 4, width of the controlled counter's q
- LEN_W, 5, width of the sweep length field

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester command valid
- req_ready  out  2  per-requester accept; a command is accepted on an edge where valid and ready are both high
- req_clr  in  2  per-requester: clear the counter to 0 before sweeping
- req_dir  in  2  per-requester direction: 1 up, 0 down
- req_len  in  2*LEN_W  per-requester enable-cycle count; requester i uses bits [i*LEN_W +: LEN_W]
- cnt_q  in  CNT_W  counter output (observed)
- cnt_rst  out  1  to counter sync reset
- cnt_en  out  1  to counter enable
- cnt_up_dn  out  1  to counter direction
- busy  out  1  high while a command is in progress
- done  out  1  one-cycle pulse in the CHECK cycle
- done_id  out  1  requester served; valid with done
- err  out  1  final-value mismatch; valid with done

## Operation
- FSM states: IDLE, CLEAR, RUN, CHECK.
- IDLE:
  - Grant goes to the valid requester holding priority. If only one requester is valid, it is granted.
  - req_ready[i] = (state==IDLE) && grant==i. Ready is combinational from req_valid; at most one bit is set.
  - On accept, latch id, dir, len and clr.
  - Start value: 0 if clr, else cnt_q sampled at the accept edge.
  - Priority pointer moves to the other requester.
- Transitions after accept:
  - clr=1 goes to CLEAR.
  - clr=0 with len≠0 goes to RUN.
  - clr=0 with len=0 goes to CHECK.
- CLEAR: cnt_rst=1 for exactly 1 cycle, then RUN if len≠0, else CHECK.
- RUN:
  - cnt_en=1 and cnt_up_dn=dir for exactly len consecutive cycles.
  - Remaining-count register decrements each cycle; RUN exits to CHECK after the last enable cycle.
- CHECK, one cycle:
  - done=1 and done_id=latched id.
  - err = (cnt_q != expected).
  - expected = (start + len) mod 2^CNT_W when up; (start − len) mod 2^CNT_W when down. len is truncated/extended to CNT_W+LEN_W bits before the modulo.
  - Next state is IDLE.
- cnt_up_dn holds the latched dir for the whole command. In IDLE it holds its last value.
- cnt_en=0 and cnt_rst=0 outside RUN and CLEAR, except during reset.
- Requester inputs are ignored while busy. A requester may change or withdraw its fields while not granted.
- Priority pointer: requester 0 after reset; it toggles only on accept.

## Timing
- Reset values (asynchronous, held while rst_n=0):
  - state=IDLE, priority=0.
  - cnt_rst=1, so the counter is held cleared.
  - cnt_en=0, cnt_up_dn=0, busy=0, done=0, done_id=0, err=0, req_ready=0.
- First edge after rst_n rises: cnt_rst=0.
- cnt_rst, cnt_en, cnt_up_dn, busy, done, done_id and err are registered, or decoded from state registers only. There is no combinational path from req_* to them.
- Accept at edge A. Relative to A:
  - CLEAR occupies cycle 1 if clr.
  - RUN occupies the next len cycles.
  - CHECK is the following cycle.
  - busy is high in all of these cycles.
- A command occupies clr+len+1 cycles after A. The next accept can occur no earlier than the edge ending the first IDLE cycle after CHECK.
- Back-to-back cadence with both requesters always valid: grants alternate 0,1,0,1,…
- rst_n asserted mid-CLEAR, RUN or CHECK:
  - Immediate abort; outputs take reset values.
  - No done is issued for the aborted command.

## Test plan
- Reset: rst_n=0 with both valid → cnt_rst=1, cnt_en=0, req_ready=00, busy=0. Release → cnt_rst=0 after the first edge; req_ready=01.
- Req0 clr=1, dir=1, len=5 → cnt_rst for 1 cycle, cnt_en for 5 cycles with up_dn=1, then done=1, done_id=0, err=0 with q=5. busy spans 7 cycles.
- Wrap: counter at 2, req1 clr=0, dir=0, len=5 → expected 13. q=13 at CHECK, err=0, done_id=1. Repeat with clr=0, up, len=20 from q=13 → expected 1.
- Round-robin: both valid continuously with len=1, clr=0 → done_id sequence 0,1,0,1. req_ready never has both bits set.
- len=0, clr=0 → no cnt_en. done is asserted in the cycle right after accept, with err=0.
- Faults:
  - Bench counter model stuck at 0 with clr=1, up, len=3 → err=1 at CHECK.
  - rst_n pulsed low in the 2nd RUN cycle → cnt_en=0 and cnt_rst=1 immediately; no done pulse follows.

Source files
------------

// File: rtl/counter_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_sweep_ctrl_if
// Purpose  : Two-requester sweep command bus (valid/ready plus command fields).
// Revision : 1.0
// ============================================================================
interface counter_sweep_ctrl_if #(
  parameter int LEN_W = 5
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0]         req_clr;
  logic [1:0]         req_dir;
  logic [2*LEN_W-1:0] req_len;

  modport master (
    output req_valid, req_clr, req_dir, req_len,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_clr, req_dir, req_len,
    output req_ready
  );
endinterface
`default_nettype wire

// File: rtl/counter_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_sweep_ctrl
// Purpose  : Round-robin sweep controller driving a shared up/down counter and
//            checking its final value at the end of every sweep.
// Revision : 1.0
// ============================================================================
module counter_sweep_ctrl #(
  parameter int CNT_W = 4,
  parameter int LEN_W = 5
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  counter_sweep_ctrl_if.slave    req,
  input  wire logic [CNT_W-1:0]  cnt_q,
  output logic                   cnt_rst,
  output logic                   cnt_en,
  output logic                   cnt_up_dn,
  output logic                   busy,
  output logic                   done,
  output logic                   done_id,
  output logic                   err
);

  localparam int SUM_W = CNT_W + LEN_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    CHECK = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               prio_q;
  logic               rst_hold_q;
  logic               id_q;
  logic               dir_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   rem_q;
  logic [CNT_W-1:0]   exp_q;

  logic               grant_w;
  logic [1:0]         ready_w;
  logic               accept_w;
  logic               sel_clr_w;
  logic               sel_dir_w;
  logic [LEN_W-1:0]   sel_len_w;
  logic [CNT_W-1:0]   start_w;
  logic [SUM_W-1:0]   exp_full_w;
  logic [CNT_W-1:0]   exp_d;

  // Priority holder wins if valid; otherwise the other requester is granted.
  always_comb begin
    grant_w = prio_q;
    if (!req.req_valid[prio_q]) begin
      grant_w = ~prio_q;
    end
    ready_w = 2'b00;
    if ((state_q == IDLE) && !rst_hold_q && (|req.req_valid)) begin
      ready_w[grant_w] = 1'b1;
    end
    accept_w  = |(ready_w & req.req_valid);
    sel_clr_w = req.req_clr[grant_w];
    sel_dir_w = req.req_dir[grant_w];
    sel_len_w = grant_w ? req.req_len[LEN_W +: LEN_W] : req.req_len[0 +: LEN_W];
    start_w   = sel_clr_w ? '0 : cnt_q;
    if (sel_dir_w) begin
      exp_full_w = SUM_W'(start_w) + SUM_W'(sel_len_w);
    end else begin
      exp_full_w = SUM_W'(start_w) - SUM_W'(sel_len_w);
    end
    exp_d = exp_full_w[CNT_W-1:0];
  end

  assign req.req_ready = ready_w;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_w) begin
          if (sel_clr_w) begin
            state_d = CLEAR;
          end else if (sel_len_w != '0) begin
            state_d = RUN;
          end else begin
            state_d = CHECK;
          end
        end
      end
      CLEAR:   state_d = (len_q != '0) ? RUN : CHECK;
      RUN:     state_d = (rem_q <= LEN_W'(1)) ? CHECK : RUN;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      rst_hold_q <= 1'b1;
      id_q       <= 1'b0;
      dir_q      <= 1'b0;
      len_q      <= '0;
      rem_q      <= '0;
      exp_q      <= '0;
    end else begin
      state_q    <= state_d;
      rst_hold_q <= 1'b0;
      if (accept_w) begin
        prio_q <= ~prio_q;
        id_q   <= grant_w;
        dir_q  <= sel_dir_w;
        len_q  <= sel_len_w;
        rem_q  <= sel_len_w;
        exp_q  <= exp_d;
      end else if (state_q == RUN) begin
        rem_q <= rem_q - LEN_W'(1);
      end
    end
  end

  // Counter reset is held from async reset until the first clock after release.
  assign cnt_rst   = rst_hold_q | (state_q == CLEAR);
  assign cnt_en    = (state_q == RUN);
  assign cnt_up_dn = dir_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == CHECK);
  assign done_id   = id_q;
  assign err       = (state_q == CHECK) && (cnt_q != exp_q);

endmodule
`default_nettype wire
